// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared types and constants for the load/store data-bus controller.
// State encodings, load/store mask values and the data path width.
package lsu_dbus_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_DRAIN = 3'd3,
    LSU_DONE  = 3'd4
  } lsu_state_e;

  localparam logic [3:0] LS_MASK_B   = 4'b0001;
  localparam logic [3:0] LS_MASK_H   = 4'b0011;
  localparam logic [3:0] LS_MASK_W   = 4'b1111;
  localparam int         LS_SIGN_BIT = 4;

endpackage

// File: rtl/lsu_dbus_ctrl_align.sv
// Lane alignment for data-bus accesses: byte enables, replicated store data, word address.
// LSU_MISALIGN_EXP_EN: flag misaligned half/word accesses instead of silently aligning them.
module lsu_align
  import lsu_dbus_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] addr_i,
  input  logic [3:0]      mask_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] addr_o,
  output logic [1:0]      addr_lo_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misalign_o
);

  logic bad;

  assign bad = ((mask_i == LS_MASK_H) && addr_i[0]) ||
               ((mask_i == LS_MASK_W) && (addr_i[1:0] != 2'b00));

`ifdef LSU_MISALIGN_EXP_EN
  assign addr_lo_o  = addr_i[1:0];
  assign misalign_o = bad;
`else
  // Drop the offending low bits so the access completes as an aligned one.
  assign addr_lo_o  = !bad ? addr_i[1:0] :
                      (mask_i == LS_MASK_H) ? {addr_i[1], 1'b0} : 2'b00;
  assign misalign_o = 1'b0;
`endif

  assign addr_o = {addr_i[XLEN-1:2], 2'b00};
  assign be_o   = mask_i << addr_lo_o;

  always_comb begin
    wdata_o = wdata_i;
    if (mask_i == LS_MASK_B)      wdata_o = {4{wdata_i[7:0]}};
    else if (mask_i == LS_MASK_H) wdata_o = {2{wdata_i[15:0]}};
  end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// Load/store controller: one EX access at a time over a req/gnt/rvalid data bus, with timeout.
// LSU_MISALIGN_EXP_EN (in lsu_align) turns misaligned half/word accesses into a misalign completion.
//
// state     | meaning
// IDLE      | no access outstanding, may accept from EX
// REQ       | dbus_req held high until granted
// WAIT      | granted, waiting for rvalid
// DRAIN     | flushed after grant, discard the pending rvalid
// DONE      | one-cycle completion pulse to the memory stage
module lsu_dbus_ctrl
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [XLEN-1:0] ex_ls_addr,
  input  logic [4:0]      ex_ls_mask,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            flush,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_load_data,
  output logic [1:0]      lsu_addr_2low,
  output logic [4:0]      lsu_l_mask,
  output logic            lsu_bus_err,
  output logic            lsu_misalign
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e      state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout;
  logic            accept;
  logic            req_q, we_q, done_q, bus_err_q, misalign_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
  logic [3:0]      be_q;
  logic [1:0]      addr_2low_q;
  logic [4:0]      l_mask_q;

  logic [XLEN-1:0] al_addr, al_wdata;
  logic [1:0]      al_lo;
  logic [3:0]      al_be;
  logic            al_misalign;

  lsu_align u_align (
    .addr_i     (ex_ls_addr),
    .mask_i     (ex_ls_mask[3:0]),
    .wdata_i    (ex_store_data),
    .addr_o     (al_addr),
    .addr_lo_o  (al_lo),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .misalign_o (al_misalign)
  );

  assign accept  = (state_q == LSU_IDLE) && ex_valid && (ex_is_load || ex_is_store) && !flush;
  assign cnt_d   = cnt_q + CW'(1);
  assign timeout = (cnt_d == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      addr_2low_q <= '0;
      l_mask_q    <= '0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            addr_q      <= al_addr;
            we_q        <= ex_is_store;
            be_q        <= al_be;
            wdata_q     <= al_wdata;
            addr_2low_q <= al_lo;
            l_mask_q    <= {ex_ls_mask[LS_SIGN_BIT], ex_ls_mask[3:0]};
            cnt_q       <= '0;
            if (al_misalign) begin
              state_q    <= LSU_DONE;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q <= LSU_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          cnt_q <= cnt_d;
          if (flush) begin
            req_q   <= 1'b0;
            state_q <= dbus_gnt ? LSU_DRAIN : LSU_IDLE;
          end else if (dbus_gnt) begin
            req_q   <= 1'b0;
            state_q <= LSU_WAIT;
          end else if (timeout) begin
            req_q       <= 1'b0;
            state_q     <= LSU_DONE;
            done_q      <= 1'b1;
            bus_err_q   <= 1'b1;
            load_data_q <= '0;
          end
        end
        LSU_WAIT: begin
          cnt_q <= cnt_d;
          if (dbus_rvalid) begin
            if (flush) begin
              state_q <= LSU_IDLE;
            end else begin
              state_q <= LSU_DONE;
              done_q  <= 1'b1;
              if (!we_q) load_data_q <= dbus_rdata;
            end
          end else if (flush) begin
            state_q <= LSU_DRAIN;
          end else if (timeout) begin
            state_q     <= LSU_DONE;
            done_q      <= 1'b1;
            bus_err_q   <= 1'b1;
            load_data_q <= '0;
          end
        end
        LSU_DRAIN: begin
          cnt_q <= cnt_d;
          if (dbus_rvalid || timeout) state_q <= LSU_IDLE;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign dbus_req      = req_q;
  assign dbus_we       = we_q;
  assign dbus_addr     = addr_q;
  assign dbus_be       = be_q;
  assign dbus_wdata    = wdata_q;
  assign lsu_done      = done_q;
  assign lsu_bus_err   = bus_err_q;
  assign lsu_misalign  = misalign_q;
  assign lsu_load_data = load_data_q;
  assign lsu_addr_2low = addr_2low_q;
  assign lsu_l_mask    = l_mask_q;
  assign lsu_stall     = (state_q == LSU_REQ) || (state_q == LSU_WAIT) ||
                         (state_q == LSU_DRAIN) || accept;

endmodule
